// File: rtl/sp_bram.sv
`default_nettype none
// ============================================================================
//  Module   : sp_bram
//  Purpose  : Single-port block RAM with a valid/ready request channel,
//             per-byte write enables, an optional output pipeline register
//             and a credit-protected first-word-fall-through read-response
//             FIFO. Read latency L = 1 + OUT_REG; FIFO depth C = L + 1.
//  Option   : SP_BRAM_CLEAR_EN - after reset, zero every word (one per cycle)
//             before accepting requests; busy is high during the sweep.
//  Ports    : clk        rising-edge clock
//             reset      synchronous, active-high
//             req_valid  request present
//             req_ready  request accepted when valid && ready
//             req_we     1 = write, 0 = read
//             req_be     byte-lane write enables (ignored for reads)
//             req_addr   word address
//             req_wdata  write data
//             rsp_valid  read data available
//             rsp_ready  consumer takes data when valid && ready
//             rsp_rdata  read data, in request order (0 when not valid)
//             busy       clear sweep in progress (0 without the option)
//  Revision : 1.0 - initial release
// ============================================================================
module sp_bram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 14,
    parameter int BYTE_W  = 8,
    parameter int OUT_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [DATA_W/BYTE_W-1:0] req_be,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy
);

    localparam int NBE   = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAT   = 1 + OUT_REG;
    localparam int C     = LAT + 1;
    localparam int CW    = $clog2(C + 1);
    localparam int PW    = $clog2(C);
    localparam logic [CW-1:0] C_CNT   = CW'(C);
    localparam logic [PW-1:0] PTR_MAX = PW'(C - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

`ifdef SP_BRAM_CLEAR_EN
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;

    // State register; reset (even mid-sweep) restarts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_addr == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        run    = (state == ST_RUN);
        busy   = (state == ST_CLEAR);
        clr_we = (state == ST_CLEAR) && !reset;
    end
`else
    always_comb begin
        run      = 1'b1;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = '0;
    end
`endif

    // ------------------------------------------------------------------
    // Flow control. Credits cover reads in the pipeline plus FIFO entries,
    // so the FIFO can never overflow. A pop in the same cycle frees a slot,
    // which keeps streaming reads at one per cycle.
    // ------------------------------------------------------------------
    logic [CW-1:0] credits;
    logic          pop;
    logic          acc_rd;
    logic          acc_wr;

    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = !reset && run && ((credits < C_CNT) || pop);
    assign acc_rd    = req_valid && req_ready && !req_we;
    assign acc_wr    = req_valid && req_ready && req_we;

    always_ff @(posedge clk) begin
        if (reset) credits <= '0;
        else       credits <= credits + CW'(acc_rd) - CW'(pop);
    end

    // ------------------------------------------------------------------
    // Memory array: one port, byte-lane writes, registered read.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_q;
    logic              s1_valid;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < NBE; i++) begin
                if (req_be[i]) mem[req_addr][i*BYTE_W +: BYTE_W] <= req_wdata[i*BYTE_W +: BYTE_W];
            end
        end
        if (acc_rd) rd_q <= mem[req_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= acc_rd;
    end

    // Last pipeline stage feeding the response FIFO.
    logic              pv;
    logic [DATA_W-1:0] pd;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;
            always_ff @(posedge clk) begin
                if (reset) s2_valid <= 1'b0;
                else       s2_valid <= s1_valid;
                if (s1_valid) s2_data <= rd_q;
            end
            assign pv = s2_valid;
            assign pd = s2_data;
        end else begin : g_no_out_reg
            assign pv = s1_valid;
            assign pd = rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO, first-word-fall-through. When empty, the pipeline
    // output is presented directly; if not taken it is stored, so the
    // same word stays at the head on the next cycle.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo [C];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     fcnt;
    logic              f_empty;
    logic              f_push;
    logic              f_pop;

    assign f_empty   = (fcnt == '0);
    assign f_push    = pv && !(pop && f_empty);
    assign f_pop     = pop && !f_empty;
    assign rsp_valid = !f_empty || pv;
    assign rsp_rdata = !f_empty ? fifo[rptr] : (pv ? pd : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (f_push) begin
                fifo[wptr] <= pd;
                wptr       <= (wptr == PTR_MAX) ? '0 : wptr + 1'b1;
            end
            if (f_pop) rptr <= (rptr == PTR_MAX) ? '0 : rptr + 1'b1;
            fcnt <= fcnt + CW'(f_push) - CW'(f_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_bram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sp_bram
//  Purpose  : Self-checking bench for sp_bram (default parameters). Keeps a
//             word-array model of the memory and a queue of expected read
//             responses; every response is compared in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sp_bram;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 14;
    localparam int BYTE_W  = 8;
    localparam int OUT_REG = 1;
    localparam int NBE     = DATA_W / BYTE_W;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [NBE-1:0]    req_be = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    sp_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYTE_W (BYTE_W),
        .OUT_REG(OUT_REG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_be   (req_be),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference state: only addresses below 64 are ever used.
    logic [DATA_W-1:0] model [64];
    logic [DATA_W-1:0] exp_q [$];

    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   pop_cnt   = 0;
    int   first_pop = -1;
    int   last_pop  = -1;
    logic s_ready;
    logic s_valid;
    logic [DATA_W-1:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: sample handshakes mid-cycle, update the model, advance.
    task automatic step();
        #1;
        s_ready = req_ready;
        s_valid = rsp_valid;
        if (!reset) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_without_read", {31'b0, rsp_valid}, 32'h0);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0]);
                    if (rsp_ready) begin
                        last_data = exp_q.pop_front();
                        pop_cnt++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                    end
                end
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    for (int b = 0; b < NBE; b++)
                        if (req_be[b]) model[req_addr[5:0]][b*BYTE_W +: BYTE_W] = req_wdata[b*BYTE_W +: BYTE_W];
                end else begin
                    exp_q.push_back(model[req_addr[5:0]]);
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            exp_q.delete();
`ifdef SP_BRAM_CLEAR_EN
            for (int a = 0; a < 64; a++) model[a] = '0;
`endif
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [NBE-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Issue one request, retrying while not ready (bounded).
    task automatic issue(input logic we, input logic [NBE-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        drive(1'b1, we, be, a, d);
        step();
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        chk("issue_accepted", {31'b0, s_ready}, 32'h1);
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Wait for req_ready after reset; returns cycles since deassertion.
    task automatic wait_ready(output int n);
        n = 1;
        #1;
        while (!req_ready && n < DEPTH + 10) begin
            step();
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int p0;
        for (int a = 0; a < 64; a++) model[a] = '0;

        // ---------------- reset ----------------
        reset = 1'b1;
        idle();
        step();
        step();
        chk("reset_cycle_ready", {31'b0, s_ready}, 32'h0);
        reset = 1'b0;
        #1;
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
`ifdef SP_BRAM_CLEAR_EN
        chk("reset_busy", {31'b0, busy}, 32'h1);
        chk("reset_ready", {31'b0, req_ready}, 32'h0);
        wait_ready(n);
        chk("clear_ready_cycle", 32'(n), 32'(DEPTH + 1));
        chk("clear_busy_done", {31'b0, busy}, 32'h0);
`else
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_ready", {31'b0, req_ready}, 32'h1);
`endif
        @(negedge clk);

        // ---------------- write / read latency ----------------
        rsp_ready = 1'b1;
        issue(1'b1, 4'hF, 14'd5, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 14'd5, 32'h0);
        step();
        chk("lat_cycle1_invalid", {31'b0, s_valid}, 32'h0);
        step();
        chk("lat_cycle2_valid", {31'b0, s_valid}, 32'h1);
        chk("lat_data", last_data, 32'hDEADBEEF);
        drain();

        // ---------------- initialise working windows ----------------
        for (int a = 0; a < 40; a++)
            if (a != 5) issue(1'b1, 4'hF, 14'(a), $urandom);

        // ---------------- partial write ----------------
        issue(1'b1, 4'hF, 14'd3, 32'h11223344);
        issue(1'b1, 4'h5, 14'd3, 32'hAABBCCDD);
        issue(1'b0, 4'h0, 14'd3, 32'h0);
        drain();
        chk("partial_write", last_data, 32'h11BB33DD);

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, 1'b0, 4'h0, 14'(a), '0);
            step();
            chk("bp_accept", {31'b0, s_ready}, 32'h1);
        end
        drive(1'b1, 1'b0, 4'h0, 14'd3, '0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_full_ready_low", {31'b0, s_ready}, 32'h0);
        end
        p0 = pop_cnt;
        first_pop = -1;
        rsp_ready = 1'b1;
        step();
        chk("bp_release_accept", {31'b0, s_ready}, 32'h1);
        drive(1'b1, 1'b0, 4'h0, 14'd4, '0);
        step();
        chk("bp_accept_last", {31'b0, s_ready}, 32'h1);
        drain();
        chk("bp_rsp_count", 32'(pop_cnt - p0), 32'd5);
        chk("bp_rsp_no_gaps", 32'(last_pop - first_pop), 32'd4);

        // ---------------- throughput ----------------
        p0 = pop_cnt;
        first_pop = -1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 4'h0, 14'($urandom_range(8, 39)), '0);
            step();
            chk("tput_ready", {31'b0, s_ready}, 32'h1);
        end
        drain();
        chk("tput_count", 32'(pop_cnt - p0), 32'd16);
        chk("tput_consecutive", 32'(last_pop - first_pop), 32'd15);

        // ---------------- random traffic ----------------
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) == 0, 4'($urandom),
                  14'($urandom_range(8, 39)), $urandom);
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        drain();

        // ---------------- reset mid-stream ----------------
        rsp_ready = 1'b0;
        issue(1'b0, 4'h0, 14'd8, '0);
        issue(1'b0, 4'h0, 14'd9, '0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 4'hF, 14'd5, 32'h0);
        step();
        chk("midrst_ready_low", {31'b0, s_ready}, 32'h0);
        reset = 1'b0;
        idle();
        rsp_ready = 1'b1;
`ifdef SP_BRAM_CLEAR_EN
        wait_ready(n);
        chk("midrst_clear_cycle", 32'(n), 32'(DEPTH + 1));
        @(negedge clk);
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_no_stale", {31'b0, s_valid}, 32'h0);
        end
        issue(1'b0, 4'h0, 14'd5, '0);
        drain();
`ifdef SP_BRAM_CLEAR_EN
        chk("midrst_addr5", last_data, 32'h0);
`else
        chk("midrst_addr5", last_data, 32'hDEADBEEF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_bram.md
Name: sp_bram

Overview:
- Parametrised single-port block-RAM with a valid/ready request channel and a buffered read-response channel.
- Adds per-byte write enables, optional output register, response backpressure and credit-based flow control.
- Serves as the generic on-chip memory for core data/instruction storage and LED/debug test tops; infers vendor BSRAM.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 14, word-address width; DEPTH = 2**ADDR_W words.
- BYTE_W, 8, bits per byte-enable lane; NBE = DATA_W/BYTE_W.
- OUT_REG, 1, 1 = extra output pipeline register; read latency L = 1 + OUT_REG.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  NBE  byte-lane write enables; ignored for reads.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes data when valid && ready.
- rsp_rdata  out  DATA_W  read data, in request order.
- busy  out  1  high while the clear sweep runs; constant 0 without the option.

Behaviour:
- Reset outputs: req_ready=0 during the reset cycle; rsp_valid=0; rsp_rdata=0; busy=0, or 1 when the clear option is compiled in.
- State RUN after reset; state CLEAR only with the option.
- Memory contents survive reset without the option.
- Requests are handled one per cycle, in order; the single port never mixes a read and a write in one cycle.
- Writes: on acceptance, lanes with req_be[i]=1 update at the next edge; others keep their value. No response is produced. A write with be=0 is a legal no-op.
- Reads: data enters the response FIFO exactly L cycles after acceptance.
- Response FIFO: depth C = L+1, first-word-fall-through; rsp_rdata holds its value while rsp_valid && !rsp_ready.
- Credit counter: counts reads in flight plus FIFO occupancy, range 0..C.
  - Incremented on read acceptance; decremented on response pop.
  - An accept and a pop in the same cycle leave it unchanged.
- Ready rules:
  - req_ready = RUN && (credits < C || pop this cycle).
  - Writes also wait on req_ready, which keeps ordering simple.
  - With rsp_ready held high, sustained read throughput is 1 per cycle.
- Read-after-write, same address, next cycle: returns the new data. Write-first semantics come from ordering; there is no bypass path.
- FIFO full with rsp_ready low: req_ready drops. No data is lost and no duplicates are issued.
- Address wrap: req_addr is used modulo DEPTH; no out-of-range state exists.
- Reset mid-operation:
  - In-flight reads and FIFO entries are discarded; credits return to 0.
  - No response issued before reset appears afterwards.
  - A write accepted in the reset cycle is dropped.
- rsp_valid never rises without a matching accepted read.

Optional Feature:
- Macro: SP_BRAM_CLEAR_EN.
- Defined:
  - After reset, the FSM enters CLEAR.
  - It writes 0 to addresses 0..DEPTH-1, one per cycle, with busy=1 and req_ready=0 throughout.
  - It moves to RUN after the last address, so req_ready first rises DEPTH+1 cycles after reset deasserts.
  - Reset during CLEAR restarts the sweep at 0.
- Undefined:
  - No CLEAR state; busy is tied to 0.
  - req_ready rises the cycle after reset deasserts; memory powers up with undefined or init-file contents.

Test Plan:
- OUT_REG=1: write 0xDEADBEEF to addr 5 with be=0xF; read addr 5 -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata=0xDEADBEEF.
- Partial write: write 0x11223344 to addr 3, then 0xAABBCCDD with be=0x5; read addr 3 -> 0x11BB33DD.
- Backpressure: rsp_ready=0, issue reads to addrs 0..4 -> req_ready drops after C=3 accepts; release rsp_ready -> exactly 3 responses then 2 more, in order, with no gaps or duplicates.
- Throughput: rsp_ready=1, 16 back-to-back reads -> req_ready never drops; 16 responses on consecutive cycles.
- Reset mid-stream: 2 reads in flight, assert reset one cycle -> rsp_valid=0 afterwards, no stale response; data at addr 5 still 0xDEADBEEF (clear option off).
- SP_BRAM_CLEAR_EN with ADDR_W=4: write 0x55 to addr 15, reset -> busy high 16 cycles, req_ready rises on cycle 17; read 15 -> 0x0.
